pc_sequencer: RTL and testbench

Program-counter and fetch sequencer that drives the 8-bit `pc` consumed by the single-cycle-per-phase MIPS demo datapath: instruction memory, control unit, register file, ALU and data memory.
- It steps each instruction through FETCH/DECODE/EXEC phases to match the registered instruction memory and ALU.
- It computes the next address from the control unit's `jump`/`branch` strobes and the ALU accumulator.
- It detects a jump-to-self as a halt.
- It takes the place of the standalone next-address block and is instantiated upstream of the instruction memory.

---
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer for the MIPS demo datapath.
// Each instruction passes through FETCH/DECODE/EXEC. A jump to its own address halts the sequencer.
module pc_sequencer #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned BR_OFF_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       stall,
  input  logic [7:0] instruction,
  input  logic       jump,
  input  logic       branch,
  input  logic [7:0] acc,
  output logic [7:0] pc,
  output logic [1:0] phase,
  output logic       pc_valid,
  output logic       halted,
  output logic [7:0] retired
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    DECODE = 2'b10,
    EXEC   = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] retired_q, retired_d;
  logic       halted_q, halted_d;
  logic       pc_valid_q;

  logic [7:0]                 seq_pc, jump_tgt, br_tgt, br_off;
  logic signed [BR_OFF_W-1:0] off_raw;
  logic                       unused_instr;

  assign off_raw      = instr_q[BR_OFF_W-1:0];
  assign br_off       = 8'(off_raw);
  assign seq_pc       = pc_q + 8'd1;
  assign br_tgt       = seq_pc + br_off;
  assign jump_tgt     = {pc_q[7:6], instr_q[5:0]};
  assign unused_instr = ^instr_q[7:6];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    halted_d  = halted_q;
    case (state_q)
      IDLE: begin
        // HALT shares the IDLE encoding; only reset can clear halted_q.
        if (!halted_q && run) state_d = FETCH;
      end
      FETCH: begin
        if (!stall) state_d = DECODE;
      end
      DECODE: begin
        if (!stall) begin
          instr_d = instruction;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          if (retired_q != 8'hFF) retired_d = retired_q + 8'd1;
          if (jump && (jump_tgt == pc_q)) begin
            halted_d = 1'b1;
            state_d  = IDLE;
          end else begin
            if (jump)                          pc_d = jump_tgt;
            else if (branch && (acc == 8'h00)) pc_d = br_tgt;
            else                               pc_d = seq_pc;
            state_d = run ? FETCH : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 8'h00;
      retired_q  <= 8'h00;
      halted_q   <= 1'b0;
      pc_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      retired_q  <= retired_d;
      halted_q   <= halted_d;
      pc_valid_q <= (state_d == FETCH);
    end
  end

  assign pc       = pc_q;
  assign phase    = state_q;
  assign pc_valid = pc_valid_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expected next-pc values flow through a scoreboard queue.
module tb_pc_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic       jump = 1'b0;
  logic       branch = 1'b0;
  logic [7:0] acc = 8'h00;
  logic [7:0] pc;
  logic [1:0] phase;
  logic       pc_valid;
  logic       halted;
  logic [7:0] retired;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_pc = 8'h00;
  logic [7:0] exp_ret = 8'h00;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall),
    .instruction(instruction), .jump(jump), .branch(branch), .acc(acc),
    .pc(pc), .phase(phase), .pc_valid(pc_valid), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ret_inc(input logic [7:0] r);
    return (r == 8'hFF) ? 8'hFF : r + 8'd1;
  endfunction

  // Precondition: DUT in FETCH, 1 time unit after the edge that entered it.
  task automatic do_instr(input string tag, input logic [7:0] ins, input logic j, input logic b,
                          input logic [7:0] a, input logic [7:0] exp_next, input logic exp_halt);
    logic [7:0] want;
    chk({tag, ".fetch_phase"}, phase, 2'b01);
    chk({tag, ".fetch_valid"}, pc_valid, 1'b1);
    chk({tag, ".fetch_pc"}, pc, m_pc);
    instruction = ins; jump = j; branch = b; acc = a;
    exp_q.push_back(exp_next);
    step();
    chk({tag, ".decode_phase"}, phase, 2'b10);
    chk({tag, ".decode_pc"}, pc, m_pc);
    step();
    chk({tag, ".exec_phase"}, phase, 2'b11);
    step();
    want = exp_q.pop_front();
    chk({tag, ".next_pc"}, pc, want);
    chk({tag, ".halted"}, halted, exp_halt);
    exp_ret = ret_inc(exp_ret);
    chk({tag, ".retired"}, retired, exp_ret);
    $display("instr %s: ins=%02h j=%0b b=%0b acc=%02h pc %02h -> %02h retired=%0d",
             tag, ins, j, b, a, m_pc, pc, retired);
    m_pc = want;
    jump = 1'b0; branch = 1'b0; acc = 8'h5A; instruction = 8'h00;
  endtask

  initial begin
    // Reset values while reset is held low
    #2;
    chk("rst.pc", pc, 8'h00);
    chk("rst.phase", phase, 2'b00);
    chk("rst.valid", pc_valid, 1'b0);
    chk("rst.halted", halted, 1'b0);
    chk("rst.retired", retired, 8'h00);
    step();
    reset = 1'b1;
    step();
    chk("idle.phase", phase, 2'b00);
    run = 1'b1;
    step();

    // Six sequential instructions
    for (int i = 0; i < 6; i++) do_instr("seq", 8'h00, 1'b0, 1'b0, 8'h00, m_pc + 8'd1, 1'b0);
    chk("seq.retired6", retired, 8'd6);

    // Backward branch wrapping below zero, then sequential wrap
    do_instr("j02", 8'h02, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0);
    do_instr("bwrap", 8'h0C, 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0);
    do_instr("seqwrap", 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Walk to 8'h41 and exercise jump / branch taken / not taken / priority
    do_instr("j3f", 8'h3F, 1'b1, 1'b0, 8'h00, 8'h3F, 1'b0);
    do_instr("to40", 8'h00, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0);
    do_instr("to41", 8'h00, 1'b0, 1'b0, 8'h00, 8'h41, 1'b0);
    do_instr("jump", 8'h17, 1'b1, 1'b0, 8'h00, 8'h57, 1'b0);
    do_instr("back41a", 8'h01, 1'b1, 1'b0, 8'h00, 8'h41, 1'b0);
    do_instr("br_taken", 8'h17, 1'b0, 1'b1, 8'h00, 8'h49, 1'b0);
    do_instr("back41b", 8'h01, 1'b1, 1'b0, 8'h00, 8'h41, 1'b0);
    do_instr("br_not", 8'h17, 1'b0, 1'b1, 8'h05, 8'h42, 1'b0);
    do_instr("prio", 8'h17, 1'b1, 1'b1, 8'h00, 8'h57, 1'b0);

    // Stall for 5 cycles in DECODE
    chk("stall.fetch", phase, 2'b01);
    exp_q.push_back(m_pc + 8'd1);
    step();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall.phase", phase, 2'b10);
      chk("stall.pc", pc, m_pc);
      chk("stall.retired", retired, exp_ret);
    end
    stall = 1'b0;
    step();
    chk("stall.exec", phase, 2'b11);
    step();
    m_pc = exp_q.pop_front();
    exp_ret = ret_inc(exp_ret);
    chk("stall.next_pc", pc, m_pc);
    chk("stall.retired_done", retired, exp_ret);
    $display("instr stall: pc -> %02h retired=%0d", pc, retired);

    // Drop run during FETCH: finish the instruction, then IDLE
    run = 1'b0;
    step();
    step();
    step();
    m_pc = m_pc + 8'd1;
    exp_ret = ret_inc(exp_ret);
    chk("norun.phase", phase, 2'b00);
    chk("norun.pc", pc, m_pc);
    chk("norun.valid", pc_valid, 1'b0);
    chk("norun.retired", retired, exp_ret);
    step();
    step();
    chk("norun.stay_idle", phase, 2'b00);
    $display("instr norun: pc -> %02h idle", pc);
    run = 1'b1;
    step();
    chk("rerun.phase", phase, 2'b01);
    step();
    chk("rerun.decode", phase, 2'b10);

    // Asynchronous reset in DECODE
    #2 reset = 1'b0;
    #1;
    chk("arst.phase", phase, 2'b00);
    chk("arst.pc", pc, 8'h00);
    chk("arst.retired", retired, 8'h00);
    chk("arst.valid", pc_valid, 1'b0);
    $display("reset in decode: pc=%02h retired=%0d", pc, retired);
    @(posedge clk);
    #1 reset = 1'b1;
    m_pc = 8'h00; exp_ret = 8'h00;
    step();

    // Halt on jump-to-self
    do_instr("j10", 8'h10, 1'b1, 1'b0, 8'h00, 8'h10, 1'b0);
    do_instr("halt", 8'h10, 1'b1, 1'b0, 8'h00, 8'h10, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("halt.pc", pc, 8'h10);
      chk("halt.halted", halted, 1'b1);
      chk("halt.phase", phase, 2'b00);
    end
    chk("halt.retired", retired, 8'd2);
    reset = 1'b0;
    #1;
    chk("unhalt.pc", pc, 8'h00);
    chk("unhalt.halted", halted, 1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    m_pc = 8'h00; exp_ret = 8'h00;
    step();

    // Retired counter saturation over 260 instructions
    for (int i = 0; i < 260; i++) do_instr("sat", 8'h00, 1'b0, 1'b0, 8'h00, m_pc + 8'd1, 1'b0);
    chk("sat.retired", retired, 8'hFF);
    chk("sat.pc", pc, 8'h04);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
